// File: rtl/sc_comp.sv
// Single-cycle RV32I computer: fetch, decode, execute, memory access and
// writeback all complete in the cycle that retires each instruction.

module ScImem (
    input  logic [6:0]  i_addr,
    output logic [31:0] o_data
);

    // Read-only program store, contents are placed here from outside the design.
    logic [31:0] RAM [0:127];

    assign o_data = RAM[i_addr];

endmodule

module ScDmem (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [6:0]  i_addr,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] r_mem [0:127];

    assign o_rdata = r_mem[i_addr];

    // Only the enabled byte lanes are written, the rest of the word is kept.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

module sc_comp (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'h37,
        OP_AUIPC  = 7'h17,
        OP_JAL    = 7'h6F,
        OP_JALR   = 7'h67,
        OP_BRANCH = 7'h63,
        OP_LOAD   = 7'h03,
        OP_STORE  = 7'h23,
        OP_IMM    = 7'h13,
        OP_REG    = 7'h33
    } opcode_t;

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [31:0] w_rs1Val;
    logic [31:0] w_rs2Val;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immU;
    logic [31:0] w_immJ;
    logic [31:0] w_pcPlus4;
    logic [31:0] w_aluB;
    logic [4:0]  w_shamt;
    logic [31:0] w_aluResult;
    logic        w_brTaken;
    logic [31:0] w_memAddr;
    logic [31:0] w_memRdata;
    logic [31:0] w_loadData;
    logic [7:0]  w_loadByte;
    logic [15:0] w_loadHalf;
    logic        w_memWe;
    logic [3:0]  w_memBe;
    logic [31:0] w_memWdata;
    logic        w_rdWe;
    logic [31:0] w_rdData;
    logic [31:0] w_nextPc;
    logic        w_unusedBits;

    ScImem U_imem (
        .i_addr (r_pc[8:2]),
        .o_data (w_instr)
    );

    ScDmem U_dmem (
        .i_clk   (clk),
        .i_we    (w_memWe & rstn),
        .i_addr  (w_memAddr[8:2]),
        .i_be    (w_memBe),
        .i_wdata (w_memWdata),
        .o_rdata (w_memRdata)
    );

    assign w_opcode  = w_instr[6:0];
    assign w_rd      = w_instr[11:7];
    assign w_funct3  = w_instr[14:12];
    assign w_rs1     = w_instr[19:15];
    assign w_rs2     = w_instr[24:20];
    assign w_immI    = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_immS    = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_immB    = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_immU    = {w_instr[31:12], 12'h000};
    assign w_immJ    = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    assign w_pcPlus4 = r_pc + 32'd4;

    assign w_rs1Val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2Val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign reg_data = (reg_sel == 5'd0) ? 32'd0 : r_regs[reg_sel];

    assign w_aluB  = (w_opcode == OP_REG) ? w_rs2Val : w_immI;
    assign w_shamt = w_aluB[4:0];

    // Bit 30 selects sub only for register ops; for shifts it picks arithmetic.
    always_comb begin
        w_aluResult = 32'd0;
        case (w_funct3)
            3'd0: w_aluResult = (w_opcode == OP_REG && w_instr[30]) ? (w_rs1Val - w_aluB) : (w_rs1Val + w_aluB);
            3'd1: w_aluResult = w_rs1Val << w_shamt;
            3'd2: w_aluResult = {31'd0, $signed(w_rs1Val) < $signed(w_aluB)};
            3'd3: w_aluResult = {31'd0, w_rs1Val < w_aluB};
            3'd4: w_aluResult = w_rs1Val ^ w_aluB;
            3'd5: w_aluResult = w_instr[30] ? 32'($signed(w_rs1Val) >>> w_shamt) : (w_rs1Val >> w_shamt);
            3'd6: w_aluResult = w_rs1Val | w_aluB;
            3'd7: w_aluResult = w_rs1Val & w_aluB;
            default: w_aluResult = 32'd0;
        endcase
    end

    always_comb begin
        w_brTaken = 1'b0;
        case (w_funct3)
            3'd0: w_brTaken = (w_rs1Val == w_rs2Val);
            3'd1: w_brTaken = (w_rs1Val != w_rs2Val);
            3'd4: w_brTaken = ($signed(w_rs1Val) < $signed(w_rs2Val));
            3'd5: w_brTaken = ($signed(w_rs1Val) >= $signed(w_rs2Val));
            3'd6: w_brTaken = (w_rs1Val < w_rs2Val);
            3'd7: w_brTaken = (w_rs1Val >= w_rs2Val);
            default: w_brTaken = 1'b0;
        endcase
    end

    assign w_memAddr  = w_rs1Val + ((w_opcode == OP_STORE) ? w_immS : w_immI);
    assign w_loadByte = 8'(w_memRdata >> {w_memAddr[1:0], 3'b000});
    assign w_loadHalf = w_memAddr[1] ? w_memRdata[31:16] : w_memRdata[15:0];

    always_comb begin
        w_loadData = w_memRdata;
        case (w_funct3)
            3'd0: w_loadData = {{24{w_loadByte[7]}}, w_loadByte};
            3'd1: w_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
            3'd4: w_loadData = {24'd0, w_loadByte};
            3'd5: w_loadData = {16'd0, w_loadHalf};
            default: w_loadData = w_memRdata;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_memBe    = 4'b1111;
        w_memWdata = w_rs2Val;
        case (w_funct3[1:0])
            2'd0: begin
                w_memBe    = 4'b0001 << w_memAddr[1:0];
                w_memWdata = {4{w_rs2Val[7:0]}};
            end
            2'd1: begin
                w_memBe    = w_memAddr[1] ? 4'b1100 : 4'b0011;
                w_memWdata = {2{w_rs2Val[15:0]}};
            end
            default: begin
                w_memBe    = 4'b1111;
                w_memWdata = w_rs2Val;
            end
        endcase
    end

    // Anything not decoded below, including malformed funct3 encodings, retires as a NOP.
    always_comb begin
        w_rdWe   = 1'b0;
        w_rdData = w_aluResult;
        w_nextPc = w_pcPlus4;
        w_memWe  = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_rdWe   = 1'b1;
                w_rdData = w_immU;
            end
            OP_AUIPC: begin
                w_rdWe   = 1'b1;
                w_rdData = r_pc + w_immU;
            end
            OP_JAL: begin
                w_rdWe   = 1'b1;
                w_rdData = w_pcPlus4;
                w_nextPc = r_pc + w_immJ;
            end
            OP_JALR: begin
                if (w_funct3 == 3'd0) begin
                    w_rdWe   = 1'b1;
                    w_rdData = w_pcPlus4;
                    w_nextPc = (w_rs1Val + w_immI) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                if (w_brTaken) begin
                    w_nextPc = r_pc + w_immB;
                end
            end
            OP_LOAD: begin
                if (w_funct3 != 3'd3 && w_funct3 != 3'd6 && w_funct3 != 3'd7) begin
                    w_rdWe   = 1'b1;
                    w_rdData = w_loadData;
                end
            end
            OP_STORE: begin
                w_memWe = (w_funct3 <= 3'd2);
            end
            OP_IMM, OP_REG: begin
                w_rdWe = 1'b1;
            end
            default: begin
                w_rdWe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_pc <= w_nextPc;
            if (w_rdWe && w_rd != 5'd0) begin
                r_regs[w_rd] <= w_rdData;
            end
        end
    end

    assign w_unusedBits = &{1'b0, w_memAddr[31:9]};

endmodule

// File: tb/tb_sc_comp.sv
// Directed-program bench for sc_comp: each program is hand-assembled, run a
// known number of cycles, and architectural state is compared to hand values.

module tb_sc_comp;

    logic        clk;
    logic        rstn;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    int assertions = 0;
    int failures   = 0;

    logic [31:0] prog [$];

    sc_comp dut (
        .clk      (clk),
        .rstn     (rstn),
        .reg_sel  (reg_sel),
        .reg_data (reg_data)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic logic [31:0] iType(input int op, input int f3, input int rd, input int rs1, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] sType(input int f3, input int rs2, input int rs1, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] bType(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] uType(input int op, input int rd, input int imm20);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] jType(input int rd, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] rType(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return iType(19, 0, rd, rs1, imm);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkReg(input string tag, input int idx, input logic [31:0] expected);
        reg_sel = 5'(idx);
        #1;
        checkOutput(tag, reg_data, expected);
    endtask

    task automatic checkPc(input string tag, input logic [31:0] expected);
        checkOutput(tag, dut.r_pc, expected);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #5;
    endtask

    // Load the queued program (rest of imem filled with nops) and apply one reset edge.
    task automatic applyStimulus();
        rstn = 1'b0;
        for (int i = 0; i < 128; i++) begin
            dut.U_imem.RAM[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
        end
        @(posedge clk);
        #5;
        rstn = 1'b1;
    endtask

    logic [31:0] exp5 [0:24];

    initial begin
        rstn    = 1'b0;
        reg_sel = 5'd0;

        $display("[TB] ALU and debug port");
        prog = {addi(7, 0, 5), addi(7, 7, -7)};
        applyStimulus();
        checkReg("alu reset x7", 7, 32'd0);
        checkPc("alu reset pc", 32'd0);
        step(1);
        checkReg("alu edge1 x7", 7, 32'd5);
        step(1);
        checkReg("alu edge2 x7", 7, 32'hFFFF_FFFE);

        $display("[TB] x0 and shifts");
        prog = {addi(0, 0, 9), uType(55, 5, 'h80000), iType(19, 5, 6, 5, 'h404), iType(19, 5, 8, 5, 4)};
        applyStimulus();
        step(4);
        checkReg("x0 stays zero", 0, 32'd0);
        checkReg("lui x5", 5, 32'h8000_0000);
        checkReg("srai x6", 6, 32'hF800_0000);
        checkReg("srli x8", 8, 32'h0800_0000);

        $display("[TB] Memory lanes");
        prog = {uType(55, 1, 'h11223), addi(1, 1, 'h344), addi(2, 0, 'hAA),
                sType(2, 1, 0, 8), sType(0, 2, 0, 9),
                iType(3, 2, 3, 0, 8), iType(3, 0, 4, 0, 9), iType(3, 4, 5, 0, 9),
                iType(3, 1, 6, 0, 10), iType(3, 5, 7, 0, 8), iType(3, 1, 8, 0, 8),
                addi(9, 0, -1), sType(2, 9, 0, 12), sType(1, 1, 0, 14), iType(3, 2, 10, 0, 12)};
        applyStimulus();
        step(15);
        checkReg("lw merged", 3, 32'h1122_AA44);
        checkReg("lb sign", 4, 32'hFFFF_FFAA);
        checkReg("lbu zero", 5, 32'h0000_00AA);
        checkReg("lh upper", 6, 32'h0000_1122);
        checkReg("lhu lower", 7, 32'h0000_AA44);
        checkReg("lh lower sign", 8, 32'hFFFF_AA44);
        checkReg("sh upper lane", 10, 32'h3344_FFFF);

        $display("[TB] Control flow");
        prog = {addi(6, 0, 1), bType(0, 0, 0, 8), addi(2, 0, 7), addi(3, 0, -1),
                jType(1, 8), addi(4, 0, 9), bType(6, 3, 6, 8), addi(5, 0, 3),
                addi(7, 0, 'h31), iType(103, 0, 8, 7, 0), addi(9, 0, 1), addi(9, 0, 2),
                addi(10, 0, 4), 32'h0000_000F, 32'h0000_05F3, addi(12, 0, 6)};
        applyStimulus();
        step(2);
        checkPc("beq taken pc", 32'h0000_000C);
        step(1);
        checkPc("after addi pc", 32'h0000_0010);
        checkReg("x3 all ones", 3, 32'hFFFF_FFFF);
        step(1);
        checkPc("jal pc", 32'h0000_0018);
        checkReg("jal link", 1, 32'h0000_0014);
        step(1);
        checkPc("bltu not taken pc", 32'h0000_001C);
        step(2);
        checkReg("fallthrough x5", 5, 32'd3);
        checkPc("before jalr pc", 32'h0000_0024);
        step(1);
        checkPc("jalr odd target", 32'h0000_0030);
        checkReg("jalr link", 8, 32'h0000_0028);
        step(1);
        checkReg("after jalr x10", 10, 32'd4);
        step(1);
        checkPc("fence pc", 32'h0000_0038);
        step(1);
        checkPc("system op pc", 32'h0000_003C);
        checkReg("system op no write", 11, 32'd0);
        step(1);
        checkReg("after nops x12", 12, 32'd6);
        checkReg("beq skipped x2", 2, 32'd0);
        checkReg("jal skipped x4", 4, 32'd0);
        checkReg("jalr skipped x9", 9, 32'd0);

        $display("[TB] Full ALU program with reset mid-run");
        prog = {addi(1, 0, 3), addi(2, 1, 4), rType(0, 0, 3, 1, 2), rType(32, 0, 4, 1, 2),
                rType(0, 2, 5, 4, 1), rType(0, 3, 6, 4, 1), rType(0, 4, 7, 1, 2), rType(0, 6, 8, 1, 2),
                rType(0, 7, 9, 1, 2), rType(0, 1, 10, 1, 2), rType(32, 5, 11, 4, 1), rType(0, 5, 12, 4, 1),
                iType(19, 2, 13, 4, -3), iType(19, 3, 14, 1, -1), iType(19, 4, 15, 1, -1), iType(19, 6, 16, 1, 16),
                iType(19, 7, 17, 2, 5), uType(23, 18, 1), iType(19, 1, 19, 1, 31), addi(20, 0, 33),
                rType(0, 1, 21, 1, 20), bType(1, 1, 2, 8), addi(22, 0, 1), bType(4, 4, 1, 8),
                addi(22, 0, 2), bType(5, 4, 1, 8), addi(23, 0, 7), bType(7, 4, 1, 8),
                addi(23, 0, 8), addi(24, 0, 1)};
        exp5 = '{32'd0, 32'd3, 32'd7, 32'd10, 32'hFFFF_FFFC, 32'd1, 32'd0, 32'd4, 32'd7, 32'd3,
                 32'h180, 32'hFFFF_FFFF, 32'h1FFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'h13, 32'd5,
                 32'h1044, 32'h8000_0000, 32'd33, 32'd6, 32'd0, 32'd7, 32'd1};
        applyStimulus();
        step(5);
        checkReg("pre-reset slt", 5, 32'd1);
        checkPc("pre-reset pc", 32'h0000_0014);
        rstn = 1'b0;
        #1;
        checkReg("reset between edges x1", 1, 32'd3);
        checkPc("reset between edges pc", 32'h0000_0014);
        step(2);
        checkPc("held reset pc", 32'd0);
        for (int i = 0; i < 32; i++) begin
            checkReg($sformatf("held reset x%0d", i), i, 32'd0);
        end
        rstn = 1'b1;
        step(27);
        checkPc("rerun end pc", 32'h0000_0078);
        for (int i = 1; i < 25; i++) begin
            checkReg($sformatf("rerun x%0d", i), i, exp5[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
